// File: rtl/mem_pkg.sv
// Shared types, AXI encodings and access-size helpers for the data-memory path.
package mem_pkg;

   typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} Mem_Size;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} dmem_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic Mem_Size size_from_funct3(input logic [2:0] funct3);
      return Mem_Size'(funct3[1:0]);
   endfunction

   function automatic logic [7:0] strobe_mask(input Mem_Size size);
      case (size)
         BYTE:    return 8'h01;
         HALF:    return 8'h03;
         WORD:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] lane, input Mem_Size size);
      case (size)
         BYTE:    return 1'b0;
         HALF:    return lane[0];
         WORD:    return |lane[1:0];
         default: return |lane;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed lane of a 64-bit read beat and sign/zero-extends it by funct3.
// Purely combinational.
module load_extend (
   input  logic [63:0] rdata_i,
   input  logic [2:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [63:0] data_o
);

   logic [63:0] shifted;
   assign shifted = rdata_i >> {lane_i, 3'b000};

   always_comb begin
      data_o = shifted;
      case (funct3_i)
         3'b000:  data_o = {{56{shifted[7]}},  shifted[7:0]};
         3'b001:  data_o = {{48{shifted[15]}}, shifted[15:0]};
         3'b010:  data_o = {{32{shifted[31]}}, shifted[31:0]};
         3'b100:  data_o = {56'd0, shifted[7:0]};
         3'b101:  data_o = {48'd0, shifted[15:0]};
         3'b110:  data_o = {32'd0, shifted[31:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_axi_unit.sv
// MEM-stage load/store unit: one single-beat AXI4 read or write per request, 3-cycle best case.
// Accepts only in IDLE (req_ready); busy stalls the pipeline until the one-cycle resp_valid pulse.
module dmem_axi_unit
   import mem_pkg::*;
#(
   parameter int ID_WIDTH    = 13,
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 64,
   parameter int DMEM_AXI_ID = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_is_store,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [2:0]              req_funct3,
   output logic                    busy,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_data,
   output logic                    resp_err,
   output logic [ID_WIDTH-1:0]     m_axi_arid,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [ID_WIDTH-1:0]     m_axi_rid,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rlast,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready
);

   dmem_state_t             state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2:0]              funct3_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic [DATA_WIDTH-1:0]   resp_data_q;
   logic                    resp_err_q, resp_valid_q;
   logic                    arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic                    aw_done_q, w_done_q;
   logic [DATA_WIDTH-1:0]   ext_data;
   logic                    aw_hs, w_hs;
   logic                    req_bad;
   Mem_Size                 req_size;
   logic                    unused_ids;

   assign unused_ids = ^{m_axi_rid, m_axi_bid};

   load_extend u_load_extend (
      .rdata_i  (m_axi_rdata),
      .lane_i   (addr_q[2:0]),
      .funct3_i (funct3_q),
      .data_o   (ext_data)
   );

   assign req_size = size_from_funct3(req_funct3);
   // Misaligned accesses and store funct3 100..111 complete with an error and never touch the bus.
   assign req_bad  = misaligned(req_addr[2:0], req_size) | (req_is_store & req_funct3[2]);
   assign aw_hs    = awvalid_q & m_axi_awready;
   assign w_hs     = wvalid_q & m_axi_wready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  funct3_q <= req_funct3;
                  if (req_bad) begin
                     resp_data_q  <= '0;
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= DONE;
                  end else if (req_is_store) begin
                     wdata_q   <= req_wdata << {req_addr[2:0], 3'b000};
                     wstrb_q   <= strobe_mask(req_size) << req_addr[2:0];
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done_q <= 1'b0;
                     w_done_q  <= 1'b0;
                     state_q   <= WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m_axi_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_axi_rvalid) begin
                  rready_q     <= 1'b0;
                  resp_data_q  <= ext_data;
                  resp_err_q   <= (m_axi_rresp != AXI_RESP_OKAY) | ~m_axi_rlast;
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
               end
               if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  bready_q     <= 1'b0;
                  resp_data_q  <= '0;
                  resp_err_q   <= (m_axi_bresp != AXI_RESP_OKAY);
                  resp_valid_q <= 1'b1;
                  state_q      <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign resp_err      = resp_err_q;

   assign m_axi_arid    = ID_WIDTH'(DMEM_AXI_ID);
   assign m_axi_araddr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign m_axi_arlen   = 8'd0;
   assign m_axi_arsize  = AXI_SIZE_8B;
   assign m_axi_arburst = AXI_BURST_INCR;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

   assign m_axi_awid    = ID_WIDTH'(DMEM_AXI_ID);
   assign m_axi_awaddr  = {addr_q[ADDR_WIDTH-1:3], 3'b000};
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = AXI_SIZE_8B;
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = 1'b1;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;

endmodule
